// File: rtl/operand_forwarding_unit_pkg.sv
// Shared types for the ALU bypass producer: bypass source codes and the
// in-flight writer slot record tracked through EX/MEM/WB.
package operand_forwarding_unit_pkg;

    localparam int REG_IDX_W = 5;
    localparam int NUM_SLOTS = 3;

    // Slot order used everywhere: 0 = EX, 1 = MEM, 2 = WB.
    localparam int SLOT_EX  = 0;
    localparam int SLOT_MEM = 1;
    localparam int SLOT_WB  = 2;

    typedef enum logic [1:0] {
        BYPASS_SRC_NONE = 2'd0,
        BYPASS_SRC_MEM  = 2'd1,
        BYPASS_SRC_WB   = 2'd2,
        BYPASS_SRC_HOLD = 2'd3
    } bypass_src_e;

    typedef struct packed {
        logic                 valid;
        logic [REG_IDX_W-1:0] rd;
        logic                 is_load;
    } slot_t;

    // A writer in EX this cycle sits in MEM next cycle, and so on; the
    // youngest matching slot is the architecturally correct producer.
    function automatic bypass_src_e slot_to_src(input logic [NUM_SLOTS-1:0] hit);
        bypass_src_e src;
        src = BYPASS_SRC_NONE;
        if (hit[SLOT_EX]) begin
            src = BYPASS_SRC_MEM;
        end else if (hit[SLOT_MEM]) begin
            src = BYPASS_SRC_WB;
        end else if (hit[SLOT_WB]) begin
            src = BYPASS_SRC_HOLD;
        end
        return src;
    endfunction

endpackage

// File: rtl/operand_forwarding_unit_slot_pipe.sv
// Three-entry EX->MEM->WB shift pipe of register writers, with per-slot
// source-index match for the two ID source operands.
module forwarding_slot_pipe
    import operand_forwarding_unit_pkg::*;
(
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 push,
    input  logic [REG_IDX_W-1:0] push_rd,
    input  logic                 push_is_load,
    input  logic                 flush,
    input  logic [REG_IDX_W-1:0] rs1,
    input  logic [REG_IDX_W-1:0] rs2,
    output logic [NUM_SLOTS-1:0] hit1,
    output logic [NUM_SLOTS-1:0] hit2,
    output logic                 ex_is_load
);

    slot_t slots [NUM_SLOTS];

    // A flush kills the instruction currently in EX, so it never reaches MEM.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                slots[i] <= '0;
            end
        end else begin
            slots[SLOT_EX]  <= push ? slot_t'{valid: 1'b1, rd: push_rd, is_load: push_is_load} : '0;
            slots[SLOT_MEM] <= flush ? '0 : slots[SLOT_EX];
            slots[SLOT_WB]  <= slots[SLOT_MEM];
        end
    end

    always_comb begin
        hit1 = '0;
        hit2 = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            hit1[i] = slots[i].valid && (rs1 != '0) && (slots[i].rd == rs1);
            hit2[i] = slots[i].valid && (rs2 != '0) && (slots[i].rd == rs2);
        end
    end

    assign ex_is_load = slots[SLOT_EX].valid & slots[SLOT_EX].is_load;

endmodule

// File: rtl/operand_forwarding_unit.sv
// ALU bypass producer: decides per issued instruction whether operands A/B
// come from the single bypass_data bus, and stalls ID when that cannot work.
module operand_forwarding_unit
    import operand_forwarding_unit_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_uses_rs1,
    input  logic                  id_uses_rs2,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic                  id_reg_write,
    input  logic                  id_is_load,
    input  logic                  flush,
    input  logic [XLEN-1:0]       mem_result,
    input  logic [XLEN-1:0]       wb_result,
    output logic                  stall,
    output logic [XLEN-1:0]       bypass_data,
    output logic                  use_bypass_a,
    output logic                  use_bypass_b
);

    logic [NUM_SLOTS-1:0] hit1;
    logic [NUM_SLOTS-1:0] hit2;
    logic [NUM_SLOTS-1:0] hit_a;
    logic [NUM_SLOTS-1:0] hit_b;
    logic                 ex_is_load;
    logic                 match_a;
    logic                 match_b;
    logic                 load_use;
    logic                 conflict;
    logic                 issue;
    logic                 push;
    bypass_src_e          src_a;
    bypass_src_e          src_b;
    bypass_src_e          sel_q;
    logic [XLEN-1:0]      hold_q;
    logic                 use_a_q;
    logic                 use_b_q;

    forwarding_slot_pipe u_slot_pipe (
        .clock        (clock),
        .reset_n      (reset_n),
        .push         (push),
        .push_rd      (id_rd),
        .push_is_load (id_is_load),
        .flush        (flush),
        .rs1          (id_rs1),
        .rs2          (id_rs2),
        .hit1         (hit1),
        .hit2         (hit2),
        .ex_is_load   (ex_is_load)
    );

    // An operand only bypasses when the ALU actually reads that source.
    assign hit_a   = id_uses_rs1 ? hit1 : '0;
    assign hit_b   = id_uses_rs2 ? hit2 : '0;
    assign match_a = |hit_a;
    assign match_b = |hit_b;
    assign src_a   = slot_to_src(hit_a);
    assign src_b   = slot_to_src(hit_b);

    // Load data is not on mem_result, and the bus carries only one source.
    assign load_use = ex_is_load & (hit_a[SLOT_EX] | hit_b[SLOT_EX]);
    assign conflict = match_a & match_b & (src_a != src_b);

    assign stall = reset_n & id_valid & ~flush & (load_use | conflict);
    assign issue = id_valid & ~stall & ~flush;
    assign push  = issue & id_reg_write & (id_rd != '0);

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            sel_q   <= BYPASS_SRC_NONE;
            use_a_q <= 1'b0;
            use_b_q <= 1'b0;
            hold_q  <= '0;
        end else begin
            hold_q <= wb_result;
            if (issue) begin
                sel_q   <= match_a ? src_a : src_b;
                use_a_q <= match_a;
                use_b_q <= match_b;
            end else begin
                sel_q   <= BYPASS_SRC_NONE;
                use_a_q <= 1'b0;
                use_b_q <= 1'b0;
            end
        end
    end

    always_comb begin
        bypass_data = '0;
        if (use_a_q | use_b_q) begin
            case (sel_q)
                BYPASS_SRC_MEM:  bypass_data = mem_result;
                BYPASS_SRC_WB:   bypass_data = wb_result;
                BYPASS_SRC_HOLD: bypass_data = hold_q;
                default:         bypass_data = '0;
            endcase
        end
    end

    assign use_bypass_a = use_a_q;
    assign use_bypass_b = use_b_q;

endmodule
